// File: rtl/morse_pkg.sv
// Shared types, constants and helpers for the Morse character sequencer.
// The pattern builder turns a compact element list into a MSB-first on/off unit stream.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int MAX_UNITS = 21;
  localparam int LEN_W     = 5;

  localparam logic [6:0] ASC_SPACE = 7'h20;
  localparam logic [6:0] ASC_0     = 7'h30;
  localparam logic [6:0] ASC_A     = 7'h41;
  localparam logic [6:0] ASC_Z     = 7'h5A;
  localparam logic [6:0] ASC_LA    = 7'h61;
  localparam logic [6:0] ASC_LZ    = 7'h7A;

  typedef struct packed {
    logic [MAX_UNITS-1:0] pattern;
    logic [LEN_W-1:0]     len;
  } morse_entry_t;

  function automatic logic [6:0] fold_case(input logic [6:0] c);
    if ((c >= ASC_LA) && (c <= ASC_LZ)) begin
      return c - 7'h20;
    end else begin
      return c;
    end
  endfunction

  // n elements, listed MSB-first in code (1 = dash); gaps and the 2-unit tail are added here.
  function automatic morse_entry_t expand(input logic [2:0] n, input logic [4:0] code);
    morse_entry_t         e;
    logic [MAX_UNITS-1:0] acc;
    logic [4:0]           rest;
    int                   units;
    acc   = '0;
    rest  = code;
    units = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < int'(n)) begin
        if (i != 0) begin
          acc   = acc << 1;
          units = units + 1;
        end
        if (rest[4]) begin
          acc   = (acc << 3) | MAX_UNITS'(3'b111);
          units = units + 3;
        end else begin
          acc   = (acc << 1) | MAX_UNITS'(1'b1);
          units = units + 1;
        end
        rest = rest << 1;
      end
    end
    units     = units + 2;
    acc       = acc << 2;
    e.pattern = acc << (MAX_UNITS - units);
    e.len     = LEN_W'(units);
    return e;
  endfunction

endpackage

// File: rtl/morse_pattern_rom.sv
// Combinational character-to-pattern lookup; unsupported codes return len = 0.
module morse_pattern_rom
  import morse_pkg::*;
(
  input  logic [6:0]           char_code,
  output logic [MAX_UNITS-1:0] pattern,
  output logic [LEN_W-1:0]     len
);

  morse_entry_t entry;

  // one item per supported code; expand() collapses to constants
  always_comb begin
    entry = '0;
    case (char_code)
      ASC_SPACE: entry = '{pattern: '0, len: LEN_W'(3)};
      7'h30: entry = expand(3'd5, 5'b11111);
      7'h31: entry = expand(3'd5, 5'b01111);
      7'h32: entry = expand(3'd5, 5'b00111);
      7'h33: entry = expand(3'd5, 5'b00011);
      7'h34: entry = expand(3'd5, 5'b00001);
      7'h35: entry = expand(3'd5, 5'b00000);
      7'h36: entry = expand(3'd5, 5'b10000);
      7'h37: entry = expand(3'd5, 5'b11000);
      7'h38: entry = expand(3'd5, 5'b11100);
      7'h39: entry = expand(3'd5, 5'b11110);
      7'h41: entry = expand(3'd2, 5'b01000);
      7'h42: entry = expand(3'd4, 5'b10000);
      7'h43: entry = expand(3'd4, 5'b10100);
      7'h44: entry = expand(3'd3, 5'b10000);
      7'h45: entry = expand(3'd1, 5'b00000);
      7'h46: entry = expand(3'd4, 5'b00100);
      7'h47: entry = expand(3'd3, 5'b11000);
      7'h48: entry = expand(3'd4, 5'b00000);
      7'h49: entry = expand(3'd2, 5'b00000);
      7'h4A: entry = expand(3'd4, 5'b01110);
      7'h4B: entry = expand(3'd3, 5'b10100);
      7'h4C: entry = expand(3'd4, 5'b01000);
      7'h4D: entry = expand(3'd2, 5'b11000);
      7'h4E: entry = expand(3'd2, 5'b10000);
      7'h4F: entry = expand(3'd3, 5'b11100);
      7'h50: entry = expand(3'd4, 5'b01100);
      7'h51: entry = expand(3'd4, 5'b11010);
      7'h52: entry = expand(3'd3, 5'b01000);
      7'h53: entry = expand(3'd3, 5'b00000);
      7'h54: entry = expand(3'd1, 5'b10000);
      7'h55: entry = expand(3'd3, 5'b00100);
      7'h56: entry = expand(3'd4, 5'b00010);
      7'h57: entry = expand(3'd3, 5'b01100);
      7'h58: entry = expand(3'd4, 5'b10010);
      7'h59: entry = expand(3'd4, 5'b10110);
      7'h5A: entry = expand(3'd4, 5'b11000);
      default: entry = '0;
    endcase
  end

  assign pattern = entry.pattern;
  assign len     = entry.len;

endmodule

// File: rtl/morse_sequencer.sv
// Accepts one ASCII character at a time and keys it out as Morse, UNIT_DIV clocks per unit.
// Every output is a register; char_ready/busy are loaded from the next-state decode.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_DIV = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       abort,
  output logic       key_out,
  output logic       busy,
  output logic       char_done,
  output logic       char_err
);

  localparam int            PW        = $clog2(UNIT_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(UNIT_DIV - 1);

  state_t               state, state_next;
  logic [6:0]           code, code_next;
  logic [MAX_UNITS-1:0] pattern, pattern_next;
  logic [LEN_W-1:0]     count, count_next;
  logic [PW-1:0]        presc, presc_next;
  logic                 key_next, done_next, err_next;
  logic [MAX_UNITS-1:0] rom_pattern;
  logic [LEN_W-1:0]     rom_len;

  morse_pattern_rom u_rom (
    .char_code (code),
    .pattern   (rom_pattern),
    .len       (rom_len)
  );

  // next-state and next-output decode
  always_comb begin
    state_next   = state;
    code_next    = code;
    pattern_next = pattern;
    count_next   = count;
    presc_next   = presc;
    key_next     = key_out;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state)
      IDLE: begin
        key_next = 1'b0;
        if (char_valid) begin
          state_next = LOAD;
          code_next  = fold_case(char_in);
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
          key_next   = 1'b0;
        end else if (rom_len == LEN_W'(0)) begin
          state_next = IDLE;
          key_next   = 1'b0;
          err_next   = 1'b1;
        end else begin
          state_next   = SEND;
          pattern_next = rom_pattern;
          count_next   = rom_len;
          presc_next   = '0;
          key_next     = rom_pattern[MAX_UNITS-1];
        end
      end
      SEND: begin
        if (abort) begin
          state_next   = IDLE;
          key_next     = 1'b0;
          count_next   = '0;
          presc_next   = '0;
          pattern_next = '0;
        end else if (presc == PRESC_MAX) begin
          presc_next = '0;
          // last unit of the character just finished
          if (count == LEN_W'(1)) begin
            state_next   = IDLE;
            key_next     = 1'b0;
            done_next    = 1'b1;
            count_next   = '0;
            pattern_next = '0;
          end else begin
            count_next   = count - LEN_W'(1);
            pattern_next = pattern << 1;
            key_next     = pattern[MAX_UNITS-2];
          end
        end else begin
          presc_next = presc + PW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        key_next   = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code       <= '0;
      pattern    <= '0;
      count      <= '0;
      presc      <= '0;
      key_out    <= 1'b0;
      char_done  <= 1'b0;
      char_err   <= 1'b0;
      char_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      code       <= code_next;
      pattern    <= pattern_next;
      count      <= count_next;
      presc      <= presc_next;
      key_out    <= key_next;
      char_done  <= done_next;
      char_err   <= err_next;
      char_ready <= (state_next == IDLE);
      busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer with UNIT_DIV = 4: vector table, corner sequences
// and random characters, all compared against a dot/dash string model.
module tb_morse_sequencer;

  localparam int UNIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       abort;
  logic       key_out;
  logic       busy;
  logic       char_done;
  logic       char_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_wave[$];

  string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits [10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  typedef struct {
    logic [6:0] c;
    int         units;
    bit         err;
  } vec_t;
  vec_t vecs [17];

  morse_sequencer #(.UNIT_DIV(UNIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .abort      (abort),
    .key_out    (key_out),
    .busy       (busy),
    .char_done  (char_done),
    .char_err   (char_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: dot/dash string -> per-unit on/off list -> per-cycle key waveform.
  task automatic build_wave(input logic [6:0] c, output bit ok, output int units);
    int    v;
    string s;
    bit    u[$];
    v  = int'(c);
    ok = 1'b1;
    s  = "";
    if (v >= 'h61 && v <= 'h7A) v = v - 32;
    if (v == 'h20) begin
      u = '{1'b0, 1'b0, 1'b0};
    end else begin
      if (v >= 'h30 && v <= 'h39) s = digits[v - 'h30];
      else if (v >= 'h41 && v <= 'h5A) s = letters[v - 'h41];
      else ok = 1'b0;
      for (int i = 0; i < s.len(); i++) begin
        if (i > 0) u.push_back(1'b0);
        if (s[i] == 8'h2E) u.push_back(1'b1);
        else begin u.push_back(1'b1); u.push_back(1'b1); u.push_back(1'b1); end
      end
      if (ok) begin u.push_back(1'b0); u.push_back(1'b0); end
    end
    units = ok ? u.size() : 0;
    exp_wave.delete();
    foreach (u[i]) repeat (UNIT) exp_wave.push_back(u[i]);
  endtask

  // Entered and left at a negedge in IDLE; drives the transfer immediately.
  task automatic run_char(input logic [6:0] c, input int exp_units, input bit exp_err,
                          input int abort_at, input int rst_at, input bit hold,
                          input bit abort_idle);
    bit ok;
    int u;
    build_wave(c, ok, u);
    check("ready_before", char_ready, 1);
    char_in    = c;
    char_valid = 1'b1;
    abort      = abort_idle;
    @(negedge clk);
    abort = 1'b0;
    if (!hold) char_valid = 1'b0;
    char_in = 7'h41 + 7'($urandom_range(0, 25));
    check("load_busy", busy, 1);
    check("load_ready", char_ready, 0);
    check("load_key", key_out, 0);
    if (exp_err) begin
      @(negedge clk);
      check("err_pulse", char_err, 1);
      check("err_key", key_out, 0);
      check("err_done", char_done, 0);
      check("err_ready", char_ready, 1);
      @(negedge clk);
      check("err_one_cycle", char_err, 0);
      return;
    end
    for (int k = 0; k < exp_units * UNIT; k++) begin
      @(negedge clk);
      check($sformatf("key[%0h:%0d]", c, k), key_out, exp_wave[k]);
      check("send_busy", busy, 1);
      check("send_ready", char_ready, 0);
      check("send_done", char_done, 0);
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort      = 1'b0;
        char_valid = 1'b0;
        check("abort_key", key_out, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", char_ready, 1);
        check("abort_done", char_done, 0);
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", char_done, 0);
          check("abort_key_low", key_out, 0);
        end
        return;
      end
      if (k == rst_at) begin
        rst        = 1'b1;
        char_valid = 1'b1;
        char_in    = 7'h45;
        @(negedge clk);
        check("rst_key", key_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", char_done, 0);
        check("rst_err", char_err, 0);
        check("rst_ready", char_ready, 1);
        rst        = 1'b0;
        char_valid = 1'b0;
        @(negedge clk);
        check("rst_no_resume", busy, 0);
        check("rst_key_low", key_out, 0);
        return;
      end
    end
    @(negedge clk);
    check("done_pulse", char_done, 1);
    check("done_key", key_out, 0);
    check("done_ready", char_ready, 1);
    check("done_busy", busy, 0);
    if (hold) begin
      char_valid = 1'b0;
      @(negedge clk);
      check("hold_not_queued", busy, 0);
      check("hold_done_once", char_done, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit         ok;
    int         units;
    int         ab;
    logic [6:0] c;

    vecs = '{
      '{7'h45, 3, 1'b0}, '{7'h54, 5, 1'b0}, '{7'h41, 7, 1'b0}, '{7'h46, 11, 1'b0},
      '{7'h30, 21, 1'b0}, '{7'h35, 11, 1'b0}, '{7'h36, 13, 1'b0}, '{7'h20, 3, 1'b0},
      '{7'h61, 7, 1'b0}, '{7'h7A, 13, 1'b0}, '{7'h39, 19, 1'b0}, '{7'h23, 0, 1'b1},
      '{7'h7B, 0, 1'b1}, '{7'h40, 0, 1'b1}, '{7'h5B, 0, 1'b1}, '{7'h2F, 0, 1'b1},
      '{7'h3A, 0, 1'b1}};

    rst        = 1'b1;
    char_in    = 7'h00;
    char_valid = 1'b0;
    abort      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_key", key_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", char_done, 0);
    check("reset_err", char_err, 0);
    check("reset_ready", char_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_char(vecs[i].c, vecs[i].units, vecs[i].err, -1, -1, 1'b0, 1'b0);
      @(negedge clk);
    end

    run_char(7'h41, 7, 1'b0, -1, -1, 1'b0, 1'b0);
    run_char(7'h61, 7, 1'b0, -1, -1, 1'b0, 1'b0);
    @(negedge clk);
    run_char(7'h30, 21, 1'b0, 10, -1, 1'b0, 1'b0);
    run_char(7'h45, 3, 1'b0, 11, -1, 1'b0, 1'b0);
    run_char(7'h54, 5, 1'b0, -1, 6, 1'b1, 1'b0);
    run_char(7'h54, 5, 1'b0, -1, -1, 1'b1, 1'b0);
    run_char(7'h45, 3, 1'b0, -1, -1, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: c = (7'h41 + 7'($urandom_range(0, 25))) | ($urandom_range(0, 1) ? 7'h20 : 7'h00);
        1: c = 7'h30 + 7'($urandom_range(0, 9));
        2: c = 7'h20;
        default: c = 7'($urandom_range(0, 127));
      endcase
      build_wave(c, ok, units);
      ab = (ok && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, units * UNIT - 1)) : -1;
      run_char(c, units, !ok, ab, -1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
